// File: rtl/burst_ram_pkg.sv
// Shared definitions for the burst RAM: the two-bit command encodings
// carried in the top bits of each input word.
package burst_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

endpackage

// File: rtl/burst_ram_mem.sv
// Single-port storage array with synchronous write and registered read.
// The array and its read register are deliberately left without reset.
module burst_ram_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wdata;
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/burst_ram.sv
// Command-driven RAM with auto-incrementing write/read address registers
// and a one-deep valid/ready output stage with sticky overflow flag.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              ovf
);

    cmd_e              cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] load_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              rd_cmd;
    logic              rd_accept;
    logic              rd_drop;
    logic              dout_live;

    assign cmd     = cmd_e'(din[DATA_W+1:DATA_W]);
    assign payload = din[DATA_W-1:0];

    // Address loads take the low payload bits; a wider address zero-fills.
    if (ADDR_W <= DATA_W) begin : g_addr_narrow
        assign load_addr = payload[ADDR_W-1:0];
    end else begin : g_addr_wide
        assign load_addr = {{(ADDR_W-DATA_W){1'b0}}, payload};
    end

    assign wr_en     = rx_valid && (cmd == CMD_WR_DATA);
    assign rd_cmd    = rx_valid && (cmd == CMD_RD_DATA);
    assign rd_accept = rd_cmd && (!tx_valid || tx_ready);
    assign rd_drop   = rd_cmd && tx_valid && !tx_ready;
    assign mem_addr  = wr_en ? wr_addr : rd_addr;

    burst_ram_mem #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .wr_en(wr_en),
        .rd_en(rd_accept),
        .addr (mem_addr),
        .wdata(payload),
        .rdata(rd_data)
    );

    // The array's read register has no reset, so dout is masked until the first read.
    assign dout = dout_live ? rd_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr   <= '0;
            rd_addr   <= '0;
            tx_valid  <= 1'b0;
            ovf       <= 1'b0;
            dout_live <= 1'b0;
        end else begin
            if (rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: wr_addr <= load_addr;
                    CMD_WR_DATA: if (AUTO_INC != 0) wr_addr <= wr_addr + ADDR_W'(1);
                    CMD_RD_ADDR: rd_addr <= load_addr;
                    CMD_RD_DATA: if (rd_accept && AUTO_INC != 0) rd_addr <= rd_addr + ADDR_W'(1);
                    default: ;
                endcase
            end
            if (rd_accept) begin
                tx_valid  <= 1'b1;
                dout_live <= 1'b1;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end
            if (rd_drop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: doc/burst_ram.md
BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 Parameter DATA_W, default 8: memory word width in bits.
REQ-002 Parameter ADDR_W, default 8: address width; depth is 2**ADDR_W words.
REQ-003 Parameter AUTO_INC, default 1: 1 = address registers post-increment after each data access; 0 = addresses static.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 din  input  DATA_W+2  bits [DATA_W+1:DATA_W] = command, bits [DATA_W-1:0] = payload.
REQ-007 rx_valid  input  1  din valid this cycle; one command consumed per cycle with rx_valid=1.
REQ-008 dout  output  DATA_W  read data, registered.
REQ-009 tx_valid  output  1  dout holds valid read data.
REQ-010 tx_ready  input  1  consumer accepts dout in a cycle with tx_valid=1.
REQ-011 ovf  output  1  sticky: read command dropped because the previous result was not accepted.

Function
REQ-012 Commands: 00 = load wr_addr from payload[ADDR_W-1:0]; 01 = write payload to mem[wr_addr]; 10 = load rd_addr from payload[ADDR_W-1:0]; 11 = read mem[rd_addr], payload ignored.
REQ-013 Payload bits above ADDR_W-1 are ignored for address loads; when ADDR_W > DATA_W, address bits above DATA_W-1 load as 0.
REQ-014 wr_addr and rd_addr are independent registers; loading one does not affect the other.
REQ-015 Write: mem[wr_addr] updated at the edge that consumes command 01; with AUTO_INC=1, wr_addr increments at the same edge, modulo 2**ADDR_W (all-ones wraps to 0).
REQ-016 Read latency 1: read consumed at edge N; at edge N dout = mem[rd_addr] and tx_valid = 1, both visible in cycle N+1.
REQ-017 With AUTO_INC=1, rd_addr increments modulo 2**ADDR_W at the edge that accepts a read; a dropped read does not increment it.
REQ-018 tx_valid and dout hold unchanged until the edge where tx_valid=1 and tx_ready=1; tx_valid then clears unless a new read is accepted at that edge.
REQ-019 Read accepted when tx_valid=0, or tx_valid=1 and tx_ready=1 (back-to-back reads give one word per cycle with tx_ready held high).
REQ-020 Read with tx_valid=1 and tx_ready=0: dropped, dout/tx_valid/rd_addr unchanged, ovf set to 1 and held until reset.
REQ-021 Write followed next cycle by a read of the same address returns the newly written data.
REQ-022 rx_valid=0: no state change except the tx handshake of REQ-018.
REQ-023 Commands 00/01/10 never modify dout or tx_valid.

Reset
REQ-024 rst_n low asynchronously forces dout=0, tx_valid=0, ovf=0, wr_addr=0, rd_addr=0, regardless of clk.
REQ-025 Memory contents are not reset and remain undefined until written.
REQ-026 Reset asserted mid-transfer discards a pending tx_valid word; the first accepted command after release is decoded normally.

Structure
REQ-027 Package burst_ram_pkg holds command encodings CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11.
REQ-028 Storage in sub-module burst_ram_mem: single-port, synchronous write, registered read, DATA_W x 2**ADDR_W, no reset; burst_ram holds decode, address counters, handshake and ovf.

Verification
REQ-029 Defaults: 00 0x10, then 01 0xA1, 01 0xA2, 01 0xA3 -> mem[0x10..0x12] = A1, A2, A3; wr_addr = 0x13.
REQ-030 10 0x10, then three 11 with tx_ready=1 -> dout A1, A2, A3 on consecutive cycles, tx_valid high three cycles; rd_addr = 0x13.
REQ-031 Wrap: 00 0xFF, 01 0x55, 01 0x66 -> mem[0xFF]=0x55, mem[0x00]=0x66; a read burst from 0xFF returns 55 then 66.
REQ-032 Backpressure: tx_ready=0, read at 0x10 then a second read -> dout stays A1, ovf=1, rd_addr = 0x11; tx_ready=1 -> tx_valid clears next cycle.
REQ-033 AUTO_INC=0: 00 0x20, 01 0x01, 01 0x02, 10 0x20, 11 -> dout 0x02, addresses unchanged.
REQ-034 rst_n pulsed low between clock edges while tx_valid=1 and ovf=1 -> tx_valid, dout and ovf become 0 immediately; after release, mem[0x10] still reads A1.
